// File: rtl/adder_error_monitor_pkg.sv
// Shared types and default sizing for the approximate-adder error monitor.
package adder_err_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 32;
  // Accumulator wide enough for 2^CNT_W samples of a (WIDTH+1)-bit error.
  localparam int DEF_ACC_W = DEF_CNT_W + DEF_WIDTH + 1;

  // Run-control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mon_state_e;

endpackage

// File: rtl/adder_error_monitor_if.sv
// Run-control, operand-beat and result bus of the error monitor.
// master = producer/consumer side (adder harness), slave = monitor.
interface adder_error_monitor_if
  import adder_err_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int ACC_W = CNT_W + WIDTH + 1
) ();

  logic             start;
  logic [CNT_W-1:0] num_samples;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH:0]   approx_sum;
  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] sample_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [ACC_W-1:0] sum_abs_err;
  logic [WIDTH:0]   max_abs_err;
  logic [WIDTH-1:0] worst_in1;
  logic [WIDTH-1:0] worst_in2;

  modport master (
    output start, num_samples, in_valid, in1, in2, approx_sum, res_ready,
    input  in_ready, res_valid, sample_cnt, err_cnt, sum_abs_err,
           max_abs_err, worst_in1, worst_in2
  );

  modport slave (
    input  start, num_samples, in_valid, in1, in2, approx_sum, res_ready,
    output in_ready, res_valid, sample_cnt, err_cnt, sum_abs_err,
           max_abs_err, worst_in1, worst_in2
  );

endinterface

// File: rtl/adder_error_monitor_abs_err.sv
// Registered exact sum and absolute error distance against an approximate
// sum. Operands are carried alongside so the consumer can record the worst
// case. Width-generic; data only, validity is tracked by the caller.
module abs_err_stage #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W:0]   approx,
  output logic [W:0]   exact,
  output logic [W:0]   err,
  output logic [W-1:0] a_q,
  output logic [W-1:0] b_q
);

  logic [W:0] exact_c;
  logic [W:0] err_c;

  // Unsigned exact sum and magnitude of its difference to the approximation.
  always_comb begin
    exact_c = {1'b0, a} + {1'b0, b};
    err_c   = (exact_c >= approx) ? (exact_c - approx) : (approx - exact_c);
  end

  // Capture result and operands when a beat is present in the stage before.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exact <= '0;
      err   <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else if (en) begin
      exact <= exact_c;
      err   <= err_c;
      a_q   <= a;
      b_q   <= b;
    end
  end

endmodule

// File: rtl/adder_error_monitor.sv
// Error-metric monitor for an approximate adder: accepts a programmed
// number of operand/approx-sum beats, runs them through a two-stage pipe
// (capture, error) and accumulates count / error count / sum / max metrics.
module adder_error_monitor
  import adder_err_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int ACC_W = CNT_W + WIDTH + 1
) (
  input  logic clk,
  input  logic rst_n,
  adder_error_monitor_if.slave bus
);

  typedef struct packed {
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH:0]   approx;
  } beat_t;

  mon_state_e       state, state_nxt;
  logic [CNT_W-1:0] n_lat;
  logic [CNT_W-1:0] acc_cnt;
  logic [2:1]       vld_pipe;   // [1] stage-1 beat, [2] stage-2 error
  beat_t            s1;

  logic [WIDTH:0]   s2_exact;
  logic [WIDTH:0]   s2_err;
  logic [WIDTH-1:0] s2_in1;
  logic [WIDTH-1:0] s2_in2;

  logic             start_ok;
  logic             fire;
  logic             last_beat;
  logic             rdy;
  logic             rv;

  logic [CNT_W-1:0] sample_cnt_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic [ACC_W-1:0] sum_abs_err_q;
  logic [WIDTH:0]   max_abs_err_q;
  logic [WIDTH-1:0] worst_in1_q;
  logic [WIDTH-1:0] worst_in2_q;

  assign start_ok  = (state == IDLE) && bus.start;
  assign fire      = rdy && bus.in_valid;
  assign last_beat = fire && ((acc_cnt + CNT_W'(1)) == n_lat);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_nxt = state;
    rdy       = 1'b0;
    rv        = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start)
          state_nxt = (bus.num_samples == '0) ? DONE : RUN;
      end
      RUN: begin
        rdy = 1'b1;
        if (last_beat) state_nxt = DRAIN;
      end
      DRAIN: begin
        // Empty pipe means the last error has already been accumulated.
        if (vld_pipe == '0) state_nxt = DONE;
      end
      DONE: begin
        rv = 1'b1;
        if (bus.res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Run length latch and accepted-beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_lat   <= '0;
      acc_cnt <= '0;
    end else if (start_ok) begin
      n_lat   <= bus.num_samples;
      acc_cnt <= '0;
    end else if (fire) begin
      acc_cnt <= acc_cnt + CNT_W'(1);
    end
  end

  // Stage 1 capture and valid shift register; the pipe never stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1       <= '0;
    end else begin
      vld_pipe <= {vld_pipe[1], fire};
      if (fire) s1 <= '{in1: bus.in1, in2: bus.in2, approx: bus.approx_sum};
    end
  end

  // Stage 2: exact sum and error distance.
  abs_err_stage #(.W(WIDTH)) u_abs_err (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (vld_pipe[1]),
    .a      (s1.in1),
    .b      (s1.in2),
    .approx (s1.approx),
    .exact  (s2_exact),
    .err    (s2_err),
    .a_q    (s2_in1),
    .b_q    (s2_in2)
  );

  // Metric accumulation; a strict compare keeps the first maximum on ties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt_q  <= '0;
      err_cnt_q     <= '0;
      sum_abs_err_q <= '0;
      max_abs_err_q <= '0;
      worst_in1_q   <= '0;
      worst_in2_q   <= '0;
    end else if (start_ok) begin
      sample_cnt_q  <= '0;
      err_cnt_q     <= '0;
      sum_abs_err_q <= '0;
      max_abs_err_q <= '0;
      worst_in1_q   <= '0;
      worst_in2_q   <= '0;
    end else if (vld_pipe[2]) begin
      sample_cnt_q  <= sample_cnt_q + CNT_W'(1);
      err_cnt_q     <= err_cnt_q + CNT_W'(s2_err != '0);
      sum_abs_err_q <= sum_abs_err_q + ACC_W'(s2_err);
      if (s2_err > max_abs_err_q) begin
        max_abs_err_q <= s2_err;
        worst_in1_q   <= s2_in1;
        worst_in2_q   <= s2_in2;
      end
    end
  end

  assign bus.in_ready    = rdy;
  assign bus.res_valid   = rv;
  assign bus.sample_cnt  = sample_cnt_q;
  assign bus.err_cnt     = err_cnt_q;
  assign bus.sum_abs_err = sum_abs_err_q;
  assign bus.max_abs_err = max_abs_err_q;
  assign bus.worst_in1   = worst_in1_q;
  assign bus.worst_in2   = worst_in2_q;

  // The exact sum is kept in stage 2 for debug visibility only.
  logic unused_exact;
  assign unused_exact = ^s2_exact;

endmodule
